// File: rtl/hist_pkg.sv
// Shared definitions for the histogram ping-pong buffer controller.
// Holds the default geometry (bins per spectrum, address and data widths),
// the drop-counter width and the stream FSM state encoding.
package hist_pkg;

  localparam int N_BINS = 1024;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam int DROP_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DROP = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc_i pulses and sticks at all-ones.
// Ports: clk, rst_n (async active-low, clears to 0), inc_i (count enable),
//        count_o (current count, registered).
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hist_buf_ctrl.sv
// Ping-pong frame-buffer controller: FFT magnitude stream -> 2-bank BRAM -> renderer.
// A complete spectrum is written to the back bank; banks swap only on frame_tick
// while the back bank holds a complete spectrum, so the display never tears.
// Frames arriving while the back bank is full (or frozen) are dropped and counted.
// Write path: beat at cycle t appears on mem_wr_* at t+1. Read path: combinational.
// Optional macro HIST_FREEZE_EN adds input `freeze` (ignore ticks, drop new frames).
// Ports: clk, rst_n, s_valid/s_data/s_last (stream, no backpressure), frame_tick,
//        disp_addr -> mem_rd_addr, mem_wr_en/mem_wr_addr/mem_wr_data, front_bank,
//        frames_dropped, frame_err.
module hist_buf_ctrl
  import hist_pkg::*;
#(
  parameter int N  = hist_pkg::N_BINS,
  parameter int AW = hist_pkg::ADDR_W,
  parameter int DW = hist_pkg::DATA_W
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef HIST_FREEZE_EN
  input  logic          freeze,
`endif
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  input  logic          frame_tick,
  input  logic [AW-1:0] disp_addr,
  output logic [AW:0]   mem_rd_addr,
  output logic          mem_wr_en,
  output logic [AW:0]   mem_wr_addr,
  output logic [DW-1:0] mem_wr_data,
  output logic          front_bank,
  output logic [DROP_W-1:0] frames_dropped,
  output logic          frame_err
);

  // Bin counter is one bit wider than an address so it can reach N and
  // stop there for over-long frames.
  localparam logic [AW:0] FULL_CNT = (AW+1)'(N);
  localparam logic [AW:0] LAST_CNT = (AW+1)'(N - 1);

  state_e        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          back_full_q, back_full_d;
  logic          front_bank_q, front_bank_d;
  logic          frame_err_q, frame_err_d;
  logic          wr_en_q, wr_en_d;
  logic [AW:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;

  logic          freeze_w;
  logic          swap;
  logic          drop_inc;
  logic          do_wr;
  logic [AW-1:0] wr_bin;

`ifdef HIST_FREEZE_EN
  assign freeze_w = freeze;
`else
  assign freeze_w = 1'b0;
`endif

  assign swap = frame_tick & back_full_q & ~freeze_w;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    back_full_d  = back_full_q;
    front_bank_d = front_bank_q;
    frame_err_d  = frame_err_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    drop_inc     = 1'b0;
    do_wr        = 1'b0;
    wr_bin       = '0;

    // Swap is resolved before the stream so a beat coinciding with the
    // tick sees the freshly emptied back bank.
    if (swap) begin
      front_bank_d = ~front_bank_q;
      back_full_d  = 1'b0;
    end

    if (s_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (back_full_d || freeze_w) begin
            drop_inc = 1'b1;
            if (!s_last) state_d = ST_DROP;
          end else begin
            do_wr  = 1'b1;
            wr_bin = '0;
            if (s_last) begin
              frame_err_d = 1'b1;
            end else begin
              cnt_d   = (AW+1)'(1);
              state_d = ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (cnt_q < FULL_CNT) begin
            do_wr  = 1'b1;
            wr_bin = cnt_q[AW-1:0];
            cnt_d  = cnt_q + 1'b1;
          end
          if (s_last) begin
            // A tick on this same beat saw back_full_q=0, so no swap yet.
            if (cnt_q == LAST_CNT) back_full_d = 1'b1;
            else                   frame_err_d = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
        ST_DROP: begin
          if (s_last) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (do_wr) begin
      wr_en_d   = 1'b1;
      wr_addr_d = {~front_bank_d, wr_bin};
      wr_data_d = s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      back_full_q  <= 1'b0;
      front_bank_q <= 1'b0;
      frame_err_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      back_full_q  <= back_full_d;
      front_bank_q <= front_bank_d;
      frame_err_q  <= frame_err_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  sat_counter #(.WIDTH(DROP_W)) u_drop_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (drop_inc),
    .count_o (frames_dropped)
  );

  assign mem_rd_addr = {front_bank_q, disp_addr};
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = wr_data_q;
  assign front_bank  = front_bank_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_hist_buf_ctrl.sv
// Bench for hist_buf_ctrl: frame-level reference model plus directed scenarios.
module tb_hist_buf_ctrl;

  localparam int NB = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        freeze;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_last;
  logic        frame_tick;
  logic [9:0]  disp_addr;
  logic [10:0] mem_rd_addr;
  logic        mem_wr_en;
  logic [10:0] mem_wr_addr;
  logic [15:0] mem_wr_data;
  logic        front_bank;
  logic [7:0]  frames_dropped;
  logic        frame_err;

  always #5 clk = ~clk;

  hist_buf_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef HIST_FREEZE_EN
    .freeze         (freeze),
`endif
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_last         (s_last),
    .frame_tick     (frame_tick),
    .disp_addr      (disp_addr),
    .mem_rd_addr    (mem_rd_addr),
    .mem_wr_en      (mem_wr_en),
    .mem_wr_addr    (mem_wr_addr),
    .mem_wr_data    (mem_wr_data),
    .front_bank     (front_bank),
    .frames_dropped (frames_dropped),
    .frame_err      (frame_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model (frame-level view) ----------------
  bit          m_in_frame, m_dropping, m_front, m_full, m_frz;
  int          m_beats;
  logic        e_wr_en;
  logic [10:0] e_wr_addr;
  logic [15:0] e_wr_data;
  int          e_drops;
  bit          e_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_in_frame = 0; m_dropping = 0; m_front = 0; m_full = 0; m_beats = 0;
      e_wr_en = 0; e_wr_addr = '0; e_wr_data = '0; e_drops = 0; e_err = 0;
    end else begin
`ifdef HIST_FREEZE_EN
      m_frz = freeze;
`else
      m_frz = 0;
`endif
      e_wr_en = 0;
      if (frame_tick && m_full && !m_frz) begin
        m_front = !m_front;
        m_full  = 0;
      end
      if (s_valid) begin
        if (!m_in_frame) begin
          if (m_full || m_frz) begin
            if (e_drops < 255) e_drops++;
            if (!s_last) begin m_in_frame = 1; m_dropping = 1; end
          end else begin
            e_wr_en = 1; e_wr_addr = {~m_front, 10'd0}; e_wr_data = s_data;
            if (s_last) e_err = 1;
            else begin m_in_frame = 1; m_dropping = 0; m_beats = 1; end
          end
        end else if (m_dropping) begin
          if (s_last) m_in_frame = 0;
        end else begin
          if (m_beats < NB) begin
            e_wr_en = 1; e_wr_addr = {~m_front, m_beats[9:0]}; e_wr_data = s_data;
          end
          if (s_last) begin
            m_in_frame = 0;
            if (m_beats == NB - 1) m_full = 1;
            else e_err = 1;
          end
          m_beats++;
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus a write log for literal checks.
  logic [15:0] bram [2048];
  int          wr_cnt;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("wr_en", 32'(mem_wr_en), 32'(e_wr_en));
      if (e_wr_en) begin
        chk("wr_addr", 32'(mem_wr_addr), 32'(e_wr_addr));
        chk("wr_data", 32'(mem_wr_data), 32'(e_wr_data));
      end
      chk("front_bank", 32'(front_bank), 32'(m_front));
      chk("frames_dropped", 32'(frames_dropped), 32'(e_drops));
      chk("frame_err", 32'(frame_err), 32'(e_err));
      chk("rd_addr", 32'(mem_rd_addr), 32'({m_front, disp_addr}));
      if (mem_wr_en) begin
        bram[mem_wr_addr] = mem_wr_data;
        wr_cnt++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic frame(input int n, input int base, input bit tick_last);
    for (int i = 0; i < n; i++) begin
      s_valid    = 1'b1;
      s_data     = 16'(base + i);
      s_last     = (i == n - 1);
      frame_tick = tick_last && (i == n - 1);
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic idle(input int k, input bit tick);
    for (int i = 0; i < k; i++) begin
      frame_tick = tick && (i == 0);
      @(posedge clk); #1;
    end
    frame_tick = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; freeze = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    frame_tick = 1'b0; disp_addr = '0; wr_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst wr_addr", 32'(mem_wr_addr), 32'd0);
    chk("rst wr_data", 32'(mem_wr_data), 32'd0);
    chk("rst front", 32'(front_bank), 32'd0);
    chk("rst drops", 32'(frames_dropped), 32'd0);
    chk("rst err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;

    // 1: full frame data=i into bank 1, then tick swaps.
    wr_cnt = 0;
    frame(NB, 0, 0); idle(2, 0);
    chk("t1 writes", 32'(wr_cnt), 32'd1024);
    chk("t1 front pre", 32'(front_bank), 32'd0);
    idle(2, 1);
    chk("t1 front", 32'(front_bank), 32'd1);
    disp_addr = 10'd5; #1;
    chk("t1 rd_addr", 32'(mem_rd_addr), 32'h405);
    chk("t1 bram5", 32'(bram[11'h405]), 32'd5);
    chk("t1 bram1023", 32'(bram[11'h7FF]), 32'd1023);

    // 2: full frame, then a second one before any tick is dropped.
    wr_cnt = 0;
    frame(NB, 100, 0); idle(2, 0);
    chk("t2 writes1", 32'(wr_cnt), 32'd1024);
    chk("t2 bram7", 32'(bram[11'h007]), 32'd107);
    wr_cnt = 0;
    frame(NB, 200, 0); idle(2, 0);
    chk("t2 writes2", 32'(wr_cnt), 32'd0);
    chk("t2 drops", 32'(frames_dropped), 32'd1);
    chk("t2 front hold", 32'(front_bank), 32'd1);
    idle(2, 1);
    chk("t2 front swap", 32'(front_bank), 32'd0);

    // 3: short frame and over-long frame both flag an error and never swap.
    wr_cnt = 0;
    frame(501, 0, 0); idle(2, 0);
    chk("t3 short writes", 32'(wr_cnt), 32'd501);
    chk("t3 err", 32'(frame_err), 32'd1);
    idle(2, 1);
    chk("t3 no swap", 32'(front_bank), 32'd0);
    wr_cnt = 0;
    frame(1100, 0, 0); idle(2, 0);
    chk("t3 long writes", 32'(wr_cnt), 32'd1024);
    idle(2, 1);
    chk("t3 no swap2", 32'(front_bank), 32'd0);

    // 4: tick on the first beat of a new frame while back bank is full.
    frame(NB, 300, 0); idle(2, 0);
    s_valid = 1'b1; s_data = 16'hABCD; s_last = 1'b0; frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    chk("t4 front", 32'(front_bank), 32'd1);
    chk("t4 wr_en", 32'(mem_wr_en), 32'd1);
    chk("t4 wr_addr", 32'(mem_wr_addr), 32'h000);
    chk("t4 wr_data", 32'(mem_wr_data), 32'hABCD);
    frame(NB - 1, 1, 0); idle(2, 0);

    // 5: tick on the completing beat does not swap; the next tick does, once.
    idle(2, 1);
    chk("t5 front a", 32'(front_bank), 32'd0);
    frame(NB, 0, 1); idle(2, 0);
    chk("t5 no swap", 32'(front_bank), 32'd0);
    idle(2, 1);
    chk("t5 swap", 32'(front_bank), 32'd1);
    idle(2, 1);
    chk("t5 once", 32'(front_bank), 32'd1);

    // 6: reset in the middle of a fill.
    for (int i = 0; i < 300; i++) begin
      s_valid = 1'b1; s_data = 16'(i); s_last = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    rst_n = 1'b0; #1;
    chk("t6 wr_en", 32'(mem_wr_en), 32'd0);
    chk("t6 wr_addr", 32'(mem_wr_addr), 32'd0);
    chk("t6 wr_data", 32'(mem_wr_data), 32'd0);
    chk("t6 front", 32'(front_bank), 32'd0);
    chk("t6 drops", 32'(frames_dropped), 32'd0);
    chk("t6 err", 32'(frame_err), 32'd0);
    idle(3, 0);
    rst_n = 1'b1;
    wr_cnt = 0;
    frame(NB, 50, 0); idle(2, 1);
    chk("t6 writes", 32'(wr_cnt), 32'd1024);
    chk("t6 front after", 32'(front_bank), 32'd1);

`ifdef HIST_FREEZE_EN
    frame(NB, 0, 0); idle(2, 0);
    freeze = 1'b1;
    idle(2, 1);
    frame(10, 0, 0);
    idle(2, 1);
    idle(2, 1);
    chk("frz front", 32'(front_bank), 32'd1);
    chk("frz drops", 32'(frames_dropped), 32'd1);
    freeze = 1'b0;
    idle(2, 1);
    chk("frz release", 32'(front_bank), 32'd0);
`endif

    idle(2, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
